// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the execute stage.
// Produces one quotient bit per cycle; signed operands are divided as magnitudes and sign-corrected at the end.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     dividend,
    input  logic [DATA_W-1:0]     divisor,
    input  logic                  div_valid1,
    input  logic                  div_valid2,
    input  logic                  div_signed,
    input  logic                  div_start,
    output logic                  div_ready_o,
    output logic [2*DATA_W-1:0]   div_result_o,
    output logic [DATA_W-1:0]     cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quot_q;
    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dsr_q;
    logic                sgn_op;
    logic                neg_dvd;
    logic                neg_dsr;

    logic                accept;
    logic                last_step;
    logic [DATA_W-1:0]   dvd_mag;
    logic [DATA_W-1:0]   dsr_mag;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quot_step;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign accept    = div_start & div_valid1 & div_valid2;
    assign last_step = (cnt_o == DATA_W'(ITER));

    assign dvd_mag = (div_signed && dividend[DATA_W-1]) ? -dividend : dividend;
    assign dsr_mag = (div_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

    // One restoring step: the 33-bit trial difference's MSB says whether the subtract "borrowed".
    assign shifted   = {rem_q, dvd_q[DATA_W-1]};
    assign diff      = shifted - {1'b0, dsr_q};
    assign q_bit     = ~diff[DATA_W];
    assign rem_step  = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quot_step = {quot_q[DATA_W-2:0], q_bit};

    assign quot_fix = (sgn_op && (neg_dvd ^ neg_dsr)) ? -quot_step : quot_step;
    assign rem_fix  = (sgn_op && neg_dvd) ? -rem_step : rem_step;

    always_comb begin
        // NOTE: next state defaults to the current one so no path through the case leaves it unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (divisor == '0) ? S_DONE : S_DIV;
            S_DIV: begin
                if (!div_start)     state_nxt = S_IDLE;
                else if (last_step) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_ready_o  <= 1'b0;
            div_result_o <= '0;
            cnt_o        <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            dvd_q        <= '0;
            dsr_q        <= '0;
            sgn_op       <= 1'b0;
            neg_dvd      <= 1'b0;
            neg_dsr      <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_ready_o <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    cnt_o <= '0;
                    if (accept) begin
                        sgn_op  <= div_signed;
                        neg_dvd <= div_signed & dividend[DATA_W-1];
                        neg_dsr <= div_signed & divisor[DATA_W-1];
                        dvd_q   <= dvd_mag;
                        dsr_q   <= dsr_mag;
                        rem_q   <= '0;
                        quot_q  <= '0;
                        // Divide-by-zero skips iteration and reports the raw dividend as remainder.
                        if (divisor == '0) div_result_o <= {{DATA_W{1'b1}}, dividend};
                        else               cnt_o        <= DATA_W'(1);
                    end
                end
                S_DIV: begin
                    if (!div_start) begin
                        cnt_o <= '0;
                    end else begin
                        rem_q  <= rem_step;
                        quot_q <= quot_step;
                        dvd_q  <= dvd_q << 1;
                        if (last_step) begin
                            cnt_o        <= '0;
                            div_result_o <= {quot_fix, rem_fix};
                        end else begin
                            cnt_o <= cnt_o + 1'b1;
                        end
                    end
                end
                default: cnt_o <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed and random divides, abort, reset and back-to-back traffic.
// Expected results and ready cycles go into a scoreboard queue at accept and are popped on each ready pulse.
module tb_div_unit;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           div_valid1;
    logic           div_valid2;
    logic           div_signed;
    logic           div_start;
    logic           div_ready_o;
    logic [2*W-1:0] div_result_o;
    logic [W-1:0]   cnt_o;

    typedef struct {
        logic [2*W-1:0] res;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc   = 0;
    logic [2*W-1:0] last_res;

    div_unit #(.DATA_W(W), .ITER(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_valid1   (div_valid1),
        .div_valid2   (div_valid2),
        .div_signed   (div_signed),
        .div_start    (div_start),
        .div_ready_o  (div_ready_o),
        .div_result_o (div_result_o),
        .cnt_o        (cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every ready pulse must match the oldest outstanding scoreboard entry, both value and cycle.
    always @(negedge clk) begin
        if (div_ready_o) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("result", div_result_o, mon_e.res);
                check("ready_cycle", mon_e.cyc, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        div_start  = 1'b0;
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sd;
        if (b == '0) return {{W{1'b1}}, a};
        if (s) begin
            sa = a;
            sd = b;
            return {W'(sa / sd), W'(sa % sd)};
        end
        return {a / b, a % b};
    endfunction

    // Accepts in the current cycle, returns in the first IDLE cycle after DONE with div_start still high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [2*W-1:0] exp);
        int lat;
        lat        = (b == '0) ? 1 : LAT;
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_start  = 1'b1;
        div_valid1 = 1'b1;
        div_valid2 = 1'b1;
        sb.push_back('{exp, cyc + lat});
        tick();
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        div_signed = ~s;
        for (int k = 1; k < lat; k++) begin
            check("cnt_run", cnt_o, k);
            check("ready_low", div_ready_o, 0);
            tick();
        end
        check("ready_pulse", div_ready_o, 1);
        check("cnt_done", cnt_o, 0);
        tick();
        check("ready_drop", div_ready_o, 0);
        check("cnt_idle", cnt_o, 0);
        check("result_hold", div_result_o, exp);
        last_res = exp;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           c0;

        rst        = 1'b1;
        dividend   = '0;
        divisor    = '0;
        div_signed = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_ready", div_ready_o, 0);
        check("rst_result", div_result_o, 0);
        check("rst_cnt", cnt_o, 0);
        rst = 1'b0;
        tick();

        // Start without both valids must not launch an operation.
        div_start  = 1'b1;
        div_valid1 = 1'b1;
        dividend   = 32'd100;
        divisor    = 32'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_valid2_cnt", cnt_o, 0);
        end
        div_valid1 = 1'b0;
        div_valid2 = 1'b1;
        tick();
        check("no_valid1_cnt", cnt_o, 0);
        idle_inputs();
        tick();

        run_op(32'd100, 32'd7, 1'b0, {32'd14, 32'd2});
        idle_inputs(); tick();
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        idle_inputs(); tick();
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFD, 32'd1});
        idle_inputs(); tick();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0});
        idle_inputs(); tick();
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {32'hFFFF_FFFF, 32'h0});
        idle_inputs(); tick();
        run_op(32'd5, 32'd0, 1'b0, {32'hFFFF_FFFF, 32'd5});
        idle_inputs(); tick();
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF9});
        idle_inputs(); tick();

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            rs = i[0];
            if (rb == '0) rb = 32'd1;
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_op(ra, rb, rs, model(ra, rb, rs));
            idle_inputs(); tick();
        end

        // Abort at cnt = 10: no ready, result untouched.
        dividend   = 32'd1000;
        divisor    = 32'd3;
        div_signed = 1'b0;
        div_start  = 1'b1;
        div_valid1 = 1'b1;
        div_valid2 = 1'b1;
        tick();
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("abort_cnt_before", cnt_o, 10);
        div_start = 1'b0;
        tick();
        check("abort_cnt", cnt_o, 0);
        check("abort_ready", div_ready_o, 0);
        check("abort_result", div_result_o, last_res);
        for (int k = 0; k < 40; k++) tick();
        check("abort_cnt_later", cnt_o, 0);

        // Reset at cnt = 20 clears everything and no ready follows.
        div_start  = 1'b1;
        div_valid1 = 1'b1;
        div_valid2 = 1'b1;
        tick();
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        check("rst_mid_cnt_before", cnt_o, 20);
        rst       = 1'b1;
        div_start = 1'b0;
        tick();
        check("rst_mid_cnt", cnt_o, 0);
        check("rst_mid_ready", div_ready_o, 0);
        check("rst_mid_result", div_result_o, 0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check("rst_mid_cnt_later", cnt_o, 0);
        run_op(32'd9, 32'd3, 1'b0, {32'd3, 32'd0});
        idle_inputs(); tick();

        // Back-to-back: second accept in the first IDLE cycle after DONE.
        c0 = cyc;
        run_op(32'd100, 32'd7, 1'b0, {32'd14, 32'd2});
        check("b2b_accept_cycle", cyc - c0, 34);
        run_op(32'd50, 32'd5, 1'b0, {32'd10, 32'd0});
        check("b2b_done_cycle", cyc - c0, 68);
        idle_inputs();
        tick();
        tick();
        tick();
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
